rate_interp_stage: RTL and testbench
====================================

Name: rate_interp_stage

Overview:
- Parametrised successor to the rate interface register: a runtime-configurable 1:L up-sampling interface between the low-rate decimated section and the high-rate filter chain.
- Each accepted input sample produces exactly L output samples, paced by an output-rate strobe.
- Mode selects zero-stuffing (sample then L-1 zeros) or zero-order hold (sample repeated L times).
- A one-entry skid buffer decouples input arrival from output phase timing.

Parameters:
- WIN, 19, data width in bits (two's complement).
- LW, 5, width of the runtime interpolation factor; maximum factor is 2^LW-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  WIN  signed input sample.
- val_in  in  1  input sample valid.
- rdy_in  out  1  block can accept a sample this cycle.
- out_stb  in  1  output-rate enable; one output phase per high cycle.
- l_factor  in  LW  interpolation factor L; 0 is treated as 1.
- mode  in  1  0 = zero-stuff, 1 = hold.
- data_out  out  WIN  signed output sample.
- val_out  out  1  one-cycle output valid pulse.
- ovf  out  1  sticky input overflow flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): data_out=0, val_out=0, ovf=0, rdy_in=1, FSM=IDLE, phase=0, cur/pend empty.
- Accept: val_in && rdy_in at a rising edge. rdy_in = !pend_valid (combinational from the register).
- Per-sample latch: l_factor (0→1) and mode are captured together with the sample. Changing the inputs mid-sample never affects samples already accepted.
- FSM IDLE:
  - On accept, load cur, set phase=0, go to EMIT.
  - The sample goes to cur, never to pend.
- FSM EMIT, on each out_stb=1 cycle:
  - Next cycle, val_out=1.
  - data_out = cur.data if phase==0 or cur.mode==1, else 0.
  - phase increments.
- Last phase (phase==cur.L-1 with out_stb=1):
  - If pend_valid: pend moves to cur, phase=0, stay in EMIT.
  - Else if an accept occurs in the same cycle: data_in goes straight to cur (bypass), phase=0, stay in EMIT.
  - Else: go to IDLE.
- Accept during EMIT, not on the last-phase bypass: the sample goes to pend and rdy_in drops the next cycle.
- Accept while pend is being drained into cur in the same cycle: not possible, because rdy_in=0 while pend is full.
- Non-valid cycles: val_out=0 and data_out=0, matching the existing rate interface convention.
- Latency: out_stb sampled at edge n gives val_out/data_out valid during cycle n+1. The earliest first output is one cycle after the out_stb following the accept edge. out_stb in the accept cycle itself does not count.
- out_stb in IDLE is ignored; no output is produced.
- Back-to-back out_stb: one phase per cycle. L=1 in that case yields a pass-through with 1-cycle latency.
- phase counter width is LW. It never exceeds cur.L-1; no wrap beyond that.

Optional Feature:
- Macro RATE_INTERP_OVF_EN.
- Defined: ovf sets when val_in=1 && rdy_in=0. The sample is dropped. ovf stays set until rst.
- Undefined: ovf is tied to 0 and no overflow logic is generated. The drop-on-full behaviour is unchanged.

Decomposition:
- Package rate_interp_pkg holds:
  - state type {IDLE, EMIT};
  - mode constants MODE_ZSTUFF=0 and MODE_HOLD=1;
  - a sample-record typedef (data, L, mode) used for cur and pend.
- Sub-module rate_interp_phase_ctr:
  - loadable phase counter with terminal-count output (phase==L-1 && out_stb);
  - instantiated once.

Test Plan:
- Reset mid-EMIT: L=4, rst pulsed after 2 phases → all outputs 0 immediately; rdy_in=1; the next sample restarts at phase 0.
- Zero-stuff: L=4, mode=0, data_in=1000, out_stb every 3rd cycle → val_out pulses carry 1000,0,0,0, each one cycle after its strobe, then IDLE.
- Hold: L=3, mode=1, data_in=-5, out_stb held high → data_out -5,-5,-5 on 3 consecutive cycles.
- Skid and back-pressure: L=2, out_stb sparse, with three val_in samples 7,8,9 sent on consecutive cycles:
  - 7 goes to cur, 8 goes to pend, rdy_in=0;
  - 9 is dropped; ovf=1 with the macro, ovf=0 without;
  - output sequence is 7,0,8,0.
- Last-phase bypass plus per-sample latching:
  - L=1, out_stb=1 continuously, val_in every cycle with 1,2,3 → outputs 1,2,3 on consecutive cycles, rdy_in always 1.
  - l_factor changed 1→3 while a sample is in EMIT → the current sample keeps L=1 and the next sample uses L=3.

Source files
------------

// File: rtl/rate_interp_pkg.sv
// Shared types for the rate interpolation stage: FSM states, mode encodings,
// and the per-sample record (data, interpolation factor, mode) used for the
// active and skid-buffered samples.
package rate_interp_pkg;

  // Default widths. The sample record is sized from these, so the stage
  // parameters must keep the same values.
  localparam int SMP_WIN = 19;
  localparam int SMP_LW  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic MODE_ZSTUFF = 1'b0;
  localparam logic MODE_HOLD   = 1'b1;

  typedef struct packed {
    logic signed [SMP_WIN-1:0] data;
    logic [SMP_LW-1:0]         l;
    logic                      mode;
  } sample_t;

  // A factor of 0 behaves as 1 (plain pass-through).
  function automatic logic [SMP_LW-1:0] norm_l(input logic [SMP_LW-1:0] l);
    return (l == '0) ? SMP_LW'(1) : l;
  endfunction

endpackage

// File: rtl/rate_interp_stage_if.sv
// Sample stream bundle for the rate interpolation stage.
// Ports: data_in/val_in/rdy_in (input side), data_out/val_out (output side).
// master = producer/consumer outside the stage, slave = the stage itself.
interface rate_interp_stage_if #(
  parameter int WIN = rate_interp_pkg::SMP_WIN
);
  logic signed [WIN-1:0] data_in;
  logic                  val_in;
  logic                  rdy_in;
  logic signed [WIN-1:0] data_out;
  logic                  val_out;

  modport master (
    output data_in,
    output val_in,
    input  rdy_in,
    input  data_out,
    input  val_out
  );

  modport slave (
    input  data_in,
    input  val_in,
    output rdy_in,
    output data_out,
    output val_out
  );
endinterface

// File: rtl/rate_interp_phase_ctr.sv
// Phase counter for one interpolated sample: counts output phases 0..L-1.
// Ports: clk, rst, load (restart at 0), adv (one phase this cycle),
// l_cur (factor of the active sample), phase, tc (last phase taken now).
module rate_interp_phase_ctr #(
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [LW-1:0] l_cur,
  output logic [LW-1:0] phase,
  output logic          tc
);

  assign tc = adv && (phase == (l_cur - LW'(1)));

  // Terminal count returns to 0 so the next sample, bypassed or drained
  // from the skid entry, starts on phase 0 without an explicit load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (load || tc) begin
      phase <= '0;
    end else if (adv) begin
      phase <= phase + LW'(1);
    end
  end

endmodule

// File: rtl/rate_interp_stage.sv
// Runtime-configurable 1:L up-sampler between the decimated section and the
// high-rate filter chain; each accepted sample yields L outputs paced by
// out_stb, as zero-stuffed (sample, then zeros) or zero-order hold.
// Ports: clk, rst (async, active high), bus (slave: data_in/val_in/rdy_in,
// data_out/val_out), out_stb, l_factor, mode, ovf.
// Option: RATE_INTERP_OVF_EN enables the sticky ovf flag; otherwise ovf = 0.
module rate_interp_stage
  import rate_interp_pkg::*;
#(
  parameter int WIN = SMP_WIN,
  parameter int LW  = SMP_LW
) (
  input  logic                clk,
  input  logic                rst,
  rate_interp_stage_if.slave  bus,
  input  logic                out_stb,
  input  logic [LW-1:0]       l_factor,
  input  logic                mode,
  output logic                ovf
);

  state_t  state, state_nxt;
  sample_t cur, pend, smp_in;
  logic    pend_vld;
  logic    acc, stb_en, tc;
  logic [LW-1:0] phase;
  logic    cur_from_in, cur_from_pend, pend_from_in, ctr_load;
  logic signed [WIN-1:0] data_q;
  logic    val_q;

  assign bus.rdy_in   = !pend_vld;
  assign acc          = bus.val_in && !pend_vld;
  assign stb_en       = (state == EMIT) && out_stb;
  assign bus.data_out = data_q;
  assign bus.val_out  = val_q;

  // Factor and mode travel with the sample, so later input changes never
  // touch samples already accepted.
  assign smp_in = '{data: bus.data_in, l: norm_l(l_factor), mode: mode};

  rate_interp_phase_ctr #(.LW(LW)) u_phase_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .adv   (stb_en),
    .l_cur (cur.l),
    .phase (phase),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_from_in   = 1'b0;
    cur_from_pend = 1'b0;
    pend_from_in  = 1'b0;
    ctr_load      = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          cur_from_in = 1'b1;
          ctr_load    = 1'b1;
          state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (tc) begin
          // rdy_in is low whenever pend is full, so draining pend and
          // accepting a new sample can never coincide.
          if (pend_vld) begin
            cur_from_pend = 1'b1;
          end else if (acc) begin
            cur_from_in = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (acc) begin
          pend_from_in = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      data_q   <= '0;
      val_q    <= 1'b0;
    end else begin
      if (cur_from_pend) begin
        cur <= pend;
      end else if (cur_from_in) begin
        cur <= smp_in;
      end

      if (pend_from_in) begin
        pend     <= smp_in;
        pend_vld <= 1'b1;
      end else if (cur_from_pend) begin
        pend_vld <= 1'b0;
      end

      // Output bus is forced to zero on non-valid cycles.
      val_q <= stb_en;
      if (stb_en && ((phase == '0) || (cur.mode == MODE_HOLD))) begin
        data_q <= cur.data;
      end else begin
        data_q <= '0;
      end
    end
  end

`ifdef RATE_INTERP_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.val_in && pend_vld) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rate_interp_stage.sv
// Directed bench for rate_interp_stage: reset, zero-stuff, hold, skid and
// drop, last-phase bypass with per-sample factor latching, reset mid-EMIT.
module tb_rate_interp_stage;
  import rate_interp_pkg::*;

  localparam int WIN = 19;
  localparam int LW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_stb;
  logic [LW-1:0] l_factor;
  logic          mode;
  logic          ovf;
  logic          exp_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int zs_exp [4];
  int sk_exp [4];

  rate_interp_stage_if #(.WIN(WIN)) bus ();

  rate_interp_stage #(.WIN(WIN), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .out_stb  (out_stb),
    .l_factor (l_factor),
    .mode     (mode),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic signed [31:0] v,
                         input logic signed [31:0] d);
    chk({tag, "_val"}, {31'd0, bus.val_out}, v);
    chk({tag, "_dat"}, bus.data_out, d);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    zs_exp = '{1000, 0, 0, 0};
    sk_exp = '{7, 0, 8, 0};
`ifdef RATE_INTERP_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    rst         = 1'b1;
    out_stb     = 1'b0;
    l_factor    = '0;
    mode        = 1'b0;
    bus.data_in = '0;
    bus.val_in  = 1'b0;
    #2;
    chk_out("reset", 0, 0);
    chk("reset_rdy", {31'd0, bus.rdy_in}, 1);
    chk("reset_ovf", {31'd0, ovf}, 0);
    tick();
    tick();
    rst = 1'b0;

    // Zero-stuff, L=4, strobe every 3rd cycle; strobe in accept cycle ignored.
    l_factor = 5'd4; mode = MODE_ZSTUFF; bus.data_in = 19'sd1000;
    bus.val_in = 1'b1; out_stb = 1'b1;
    tick();
    chk_out("zs_acc", 0, 0);
    bus.val_in = 1'b0; bus.data_in = '0; l_factor = '0; mode = MODE_HOLD;
    for (int k = 0; k < 12; k++) begin
      out_stb = (k % 3 == 0);
      tick();
      if (k % 3 == 0) chk_out("zs_ph", 1, zs_exp[k/3]);
      else            chk_out("zs_gap", 0, 0);
    end
    out_stb = 1'b1;
    tick();
    chk_out("zs_idle", 0, 0);
    chk("zs_idle_rdy", {31'd0, bus.rdy_in}, 1);

    // Hold, L=3, strobe held high.
    out_stb = 1'b0; l_factor = 5'd3; mode = MODE_HOLD;
    bus.data_in = -19'sd5; bus.val_in = 1'b1;
    tick();
    bus.val_in = 1'b0; mode = MODE_ZSTUFF; out_stb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("hold_ph", 1, -5);
    end
    tick();
    chk_out("hold_end", 0, 0);
    out_stb = 1'b0;

    // Skid and back-pressure, L=2: 7 to cur, 8 to pend, 9 dropped.
    l_factor = 5'd2; mode = MODE_ZSTUFF; bus.val_in = 1'b1;
    bus.data_in = 19'sd7;
    tick();
    chk("sk_rdy_a", {31'd0, bus.rdy_in}, 1);
    bus.data_in = 19'sd8;
    tick();
    chk("sk_rdy_b", {31'd0, bus.rdy_in}, 0);
    bus.data_in = 19'sd9;
    tick();
    chk("sk_rdy_c", {31'd0, bus.rdy_in}, 0);
    chk("sk_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    bus.val_in = 1'b0; bus.data_in = '0;
    out_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("sk_ph", 1, sk_exp[k]);
      if (k == 1) chk("sk_rdy_drain", {31'd0, bus.rdy_in}, 1);
    end
    tick();
    chk_out("sk_end", 0, 0);

    // Last-phase bypass, L=1, strobe and val_in every cycle.
    l_factor = 5'd1; mode = MODE_ZSTUFF; out_stb = 1'b1; bus.val_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.data_in = WIN'(k);
      if (k == 4) l_factor = 5'd3;
      tick();
      if (k == 1) chk_out("byp_first", 0, 0);
      else        chk_out("byp_out", 1, k - 1);
      chk("byp_rdy", {31'd0, bus.rdy_in}, 1);
    end
    bus.val_in = 1'b0; bus.data_in = '0; l_factor = 5'd1;
    tick();
    chk_out("lat_ph0", 1, 4);
    tick();
    chk_out("lat_ph1", 1, 0);
    tick();
    chk_out("lat_ph2", 1, 0);
    tick();
    chk_out("lat_end", 0, 0);
    chk("ovf_sticky", {31'd0, ovf}, {31'd0, exp_ovf});
    out_stb = 1'b0;

    // Reset mid-EMIT with pend full.
    l_factor = 5'd4; mode = MODE_HOLD; bus.data_in = 19'sd77; bus.val_in = 1'b1;
    tick();
    bus.data_in = 19'sd99; out_stb = 1'b1;
    tick();
    chk_out("pre_rst_a", 1, 77);
    bus.val_in = 1'b0; bus.data_in = '0;
    tick();
    chk_out("pre_rst_b", 1, 77);
    chk("pre_rst_rdy", {31'd0, bus.rdy_in}, 0);
    out_stb = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 0, 0);
    chk("mid_rst_rdy", {31'd0, bus.rdy_in}, 1);
    chk("mid_rst_ovf", {31'd0, ovf}, 0);
    tick();
    rst = 1'b0;
    l_factor = 5'd2; mode = MODE_HOLD; bus.data_in = 19'sd12; bus.val_in = 1'b1;
    tick();
    bus.val_in = 1'b0; bus.data_in = '0; out_stb = 1'b1;
    tick();
    chk_out("post_rst_a", 1, 12);
    tick();
    chk_out("post_rst_b", 1, 12);
    tick();
    chk_out("post_rst_end", 0, 0);
    out_stb = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
